bcd_display_scanner: RTL
========================

// Module: bcd_display_scanner
// PURPOSE
//   Consumes the bcd converter's output (sign, hundreds, tens, ones, data_ready) and time-multiplexes it onto a 4-digit common-anode 7-segment display.
//   Captures each new result and applies it only at digit-slot boundaries, so a digit never changes while it is lit.
//   Applies leading-zero blanking and inserts a dead time between digits to prevent ghosting.
// PARAMETERS
//   REFRESH_BITS  16  slot-counter width; each digit slot lasts 2**REFRESH_BITS clk cycles
//   DEAD_CYCLES   4   cycles at the start of each slot with all anodes off (must be < 2**REFRESH_BITS)
// PORTS
//   clk         in   1  system clock, all logic on rising edge
//   rst         in   1  synchronous reset, active-high
//   sign        in   1  1 = negative value
//   hundreds    in   4  BCD hundreds digit
//   tens        in   4  BCD tens digit
//   ones        in   4  BCD ones digit
//   data_ready  in   1  one-cycle strobe: sign/hundreds/tens/ones are valid
//   an          out  4  anode enables, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=sign
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low; held 1 (off)
// BEHAVIOUR
//   Reset (sync, rst=1 at the edge): an=4'b1111, seg=7'b1111111, dp=1.
//     Slot counter=0, digit index=0, pending and active registers all 0.
//     Reset asserted mid-frame takes effect on that edge.
//   Slot counter cnt counts 0..2**REFRESH_BITS-1 and wraps.
//     On wrap, digit index advances 0->1->2->3->0 (ones, tens, hundreds, sign).
//   Capture: on any edge with data_ready=1, pending <= {sign,hundreds,tens,ones}.
//   Commit: on every edge where cnt wraps to 0, active <= pending.
//     If data_ready coincides with that edge, active takes the old pending value.
//     The new value is committed at the next slot boundary.
//   Outputs are registered and computed from the current cnt, index and active values.
//     Updated outputs appear one cycle after the state change.
//   Dead time: while cnt < DEAD_CYCLES, an=4'b1111 and seg=7'b1111111.
//     Otherwise, exactly one an bit is low, selected by index.
//   Digit encoding (0..9): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
//   Any BCD nibble > 9 shows 'E' = 7'b0000110 and is never blanked.
//   Blanking:
//     hundreds==0 -> blank (1111111).
//     tens==0 && hundreds==0 -> blank.
//     ones is always shown.
//   Sign digit: '-' (7'b0111111) when sign=1, else blank.
//   A blanked digit still drives its anode low, with seg all off.
//   Full frame = 4 * 2**REFRESH_BITS cycles. There is no back-pressure: a newer capture before a commit overwrites pending (last value wins).
// TESTING (bench: REFRESH_BITS=4, DEAD_CYCLES=2, so slot=16 cycles, frame=64 cycles)
//   1. Reset:
//        rst=1 for 3 cycles -> an=1111, seg=1111111, dp=1.
//        After release: dead time (cycles 0-1 of slot 0), then an=1110, seg=1000000 ('0').
//   2. Value 123:
//        Pulse data_ready with sign=0, hundreds=1, tens=2, ones=3.
//        Next frame -> an=1110/seg=0110000, an=1101/0100100, an=1011/1111001, an=0111/1111111.
//   3. Value -38:
//        Pulse data_ready with sign=1, hundreds=0, tens=3, ones=8.
//        -> ones=0000000, tens=0110000, hundreds blank (an=1011, seg=1111111), sign=0111111.
//   4. Invalid BCD:
//        Pulse data_ready with ones=4'hA, hundreds=0, tens=0.
//        -> ones slot seg=0000110; tens and hundreds blank.
//   5. Boundary collision:
//        data_ready with 5 asserted on the cnt-wrap edge while pending holds 3.
//        -> that slot shows 3; the following slot shows 5.
//   6. Mid-frame reset:
//        Assert rst while an=1101.
//        -> next cycle an=1111 and seg=1111111.
//        After release: scan restarts at index 0 and display shows '0'.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//   Time-multiplexes a signed 3-digit BCD value onto a 4-digit common-anode
//   7-segment display (ones, tens, hundreds, sign).
//   - New values are captured into a pending register on data_ready.
//   - The pending value is committed to the displayed (active) value only at
//     digit-slot boundaries, so a lit digit never changes mid-slot.
//   - Leading zeros of hundreds/tens are blanked; nibbles above 9 show 'E'.
//   - Each slot starts with DEAD_CYCLES of all-anodes-off to avoid ghosting.
//   All outputs are registered and active-low.
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int REFRESH_BITS = 16,
  parameter int DEAD_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sign,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       data_ready,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // Digit slots in scan order; the value doubles as the anode bit position.
  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_SIGN     = 2'd3
  } digit_t;

  typedef struct packed {
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_value_t;

  localparam logic [REFRESH_BITS-1:0] DEAD_LIMIT = REFRESH_BITS'(DEAD_CYCLES);
  localparam logic [REFRESH_BITS-1:0] CNT_LAST   = '1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERROR = 7'b0000110;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  logic [REFRESH_BITS-1:0] cnt;
  digit_t                  idx;
  bcd_value_t              pending;
  bcd_value_t              active;
  logic                    slot_wrap;

  logic [3:0]              an_next;
  logic [6:0]              seg_next;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; anything above 9 reads as 'E'.
  function automatic logic [6:0] encode_digit(input logic [3:0] d);
    case (d)
      4'd0:    encode_digit = 7'b1000000;
      4'd1:    encode_digit = 7'b1111001;
      4'd2:    encode_digit = 7'b0100100;
      4'd3:    encode_digit = 7'b0110000;
      4'd4:    encode_digit = 7'b0011001;
      4'd5:    encode_digit = 7'b0010010;
      4'd6:    encode_digit = 7'b0000010;
      4'd7:    encode_digit = 7'b1111000;
      4'd8:    encode_digit = 7'b0000000;
      4'd9:    encode_digit = 7'b0010000;
      default: encode_digit = SEG_ERROR;
    endcase
  endfunction

  assign slot_wrap = (cnt == CNT_LAST);

  // Decimal point is never used.
  assign dp = 1'b1;

  // Next anode/segment pattern from the current slot position and active value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    an_next  = 4'b1111;
    seg_next = SEG_BLANK;
    if (cnt >= DEAD_LIMIT) begin
      an_next = ~(4'b0001 << idx);
      unique case (idx)
        DIG_ONES: seg_next = encode_digit(active.ones);
        DIG_TENS: begin
          if (active.tens > 4'd9)
            seg_next = SEG_ERROR;
          else if (active.tens == 4'd0 && active.hundreds == 4'd0)
            seg_next = SEG_BLANK;
          else
            seg_next = encode_digit(active.tens);
        end
        DIG_HUNDREDS: begin
          if (active.hundreds == 4'd0)
            seg_next = SEG_BLANK;
          else
            seg_next = encode_digit(active.hundreds);
        end
        DIG_SIGN: seg_next = active.sign ? SEG_MINUS : SEG_BLANK;
        default:  seg_next = SEG_BLANK;
      endcase
    end
  end

  // Slot counter, digit index, capture/commit registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= DIG_ONES;
      pending <= '0;
      active  <= '0;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_wrap) begin
        idx    <= digit_t'(idx + 2'd1);
        // NOTE: non-blocking assignment makes a same-edge capture land in pending
        // only after active has already taken the previous pending value.
        active <= pending;
      end
      if (data_ready)
        pending <= '{sign: sign, hundreds: hundreds, tens: tens, ones: ones};
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
